uart_rx_fifo_param: RTL
=======================

// Module: uart_rx_fifo_param
// PURPOSE
//  Parametrised UART receiver: 2-flop rx synchroniser, runtime baud divider with N-times oversampling,
//  configurable data bits/stop bits, show-ahead RX FIFO, sticky error/overrun flags and level IRQ.
//  Next-generation RX core inside the APB_UART; the APB register layer drives config and pops the FIFO.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, legal 5..8, LSB first
//  OVERSAMPLE  16  oversample ticks per bit, even, >=4
//  DIV_W       16  width of baud_div
//  FIFO_DEPTH  16  RX FIFO entries, power of two >=2
// PORTS
//  pclk        in   1              clock, all logic rising-edge
//  prst        in   1              synchronous reset, active-high
//  baud_div    in   DIV_W          oversample tick every baud_div+1 pclk cycles
//  stop2       in   1              1 = two stop bits checked
//  parity_en   in   1              parity bit present (UART_RX_PARITY_EN only)
//  parity_odd  in   1              1 = odd, 0 = even parity
//  irq_level   in   $clog2(FIFO_DEPTH+1)  IRQ threshold on fifo_count
//  rx          in   1              serial input, async, idle high
//  rd_en       in   1              pop FIFO head
//  rd_data     out  DATA_BITS+2    {parity_err, frame_err, data} at FIFO head
//  rd_valid    out  1              FIFO not empty
//  fifo_count  out  $clog2(FIFO_DEPTH+1)  entries held
//  overrun     out  1              sticky: frame dropped because FIFO was full
//  clr_ovr     in   1              single-cycle clear of overrun
//  baud_tick   out  1              oversample tick strobe (bench sync)
//  uart_irq    out  1              (fifo_count>=irq_level && irq_level!=0) || overrun
// BEHAVIOUR
//  Reset: sync regs=1, FSM IDLE, divider/counters 0, FIFO empty, rd_valid=0, fifo_count=0, overrun=0,
//   baud_tick=0, uart_irq=0, rd_data=0. Reset mid-frame abandons the frame; no partial push.
//  Divider: free-running, reloads at baud_div; baud_tick high 1 cycle per period; baud_div change takes
//   effect on next reload. baud_div=0 -> tick every cycle.
//  FSM on baud_tick, sub-count s in 0..OVERSAMPLE-1:
//   IDLE:   synced rx=0 -> START, s=0.
//   START:  at s=OVERSAMPLE/2-1 sample; rx=1 -> IDLE (glitch, nothing pushed); else s=0 -> DATA.
//   DATA:   sample at s=OVERSAMPLE-1 (mid-bit), shift in LSB first; after DATA_BITS -> PARITY or STOP.
//   PARITY: sample; parity_err = XOR(data,bit) != parity_odd.
//   STOP:   sample stop bit(s); any 0 -> frame_err=1. After last stop sample push and -> IDLE.
//  Push: 1 cycle after final stop sample; rd_valid rises the following cycle. Error frames are pushed
//   with flags set; data as received.
//  FIFO: show-ahead; rd_data valid whenever rd_valid. rd_en while empty ignored.
//   Push when full and no pop -> frame dropped, overrun=1. Push+pop same cycle when full -> both
//   accepted, count unchanged. Push+pop when empty -> push only. Pointers wrap modulo FIFO_DEPTH.
//  overrun: set beats clr_ovr in the same cycle.
//  uart_irq is combinational from registered count/overrun (no extra latency).
// CONFIGURATION
//  UART_RX_PARITY_EN defined: parity_en/parity_odd honoured, PARITY state present.
//  Undefined: PARITY state removed, parity_en/parity_odd ignored, rd_data[DATA_BITS+1] tied 0.
// TESTING
//  pclk 10 ns, OVERSAMPLE=16, baud_div=3 (bit = 64 cycles); drive rx per bit, align to baud_tick.
//  1 Frames 0xC5,0x0D,0xE9,0xA1,0xF0,0x0F,0xFF,0x00, 1 stop -> 8 pops return same order, flags 0.
//  2 rx low pulse 20 cycles in IDLE -> start rejected, fifo_count stays 0, no push.
//  3 Stop bit driven 0 on 0x5A -> entry {0,1,0x5A}; stop2=1 with 2nd stop 0 -> frame_err=1.
//  4 (PARITY_EN) parity_en=1, odd, 0x01 with parity bit 1 -> parity_err=1; bit 0 -> parity_err=0.
//  5 FIFO_DEPTH+1 frames with no reads -> count=16, 17th dropped, overrun=1, uart_irq=1; clr_ovr clears.
//  6 irq_level=2: after 1 frame irq=0, after 2nd irq=1; prst asserted mid-DATA -> all outputs reset values.

Source files
------------

// File: rtl/uart_rx_fifo_param.sv
// uart_rx_fifo_param: oversampling UART receiver with show-ahead RX FIFO, sticky overrun and level IRQ.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_fifo_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              pclk,
    input  logic                              prst,
    input  logic [DIV_W-1:0]                  baud_div,
    input  logic                              stop2,
    input  logic                              parity_en,
    input  logic                              parity_odd,
    input  logic [$clog2(FIFO_DEPTH+1)-1:0]   irq_level,
    input  logic                              rx,
    input  logic                              rd_en,
    output logic [DATA_BITS+1:0]              rd_data,
    output logic                              rd_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overrun,
    input  logic                              clr_ovr,
    output logic                              baud_tick,
    output logic                              uart_irq
);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
    logic unused_cfg;
    assign unused_cfg = parity_en ^ parity_odd;
`endif
    state_t state, state_n;
    logic rx_m, rx_s;
    logic [DIV_W-1:0] div_cnt, div_lim;
    logic [SW-1:0] s_cnt, s_n;
    logic [BW-1:0] bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shreg, sh_n;
    logic perr, perr_n, ferr, ferr_n, stop_idx, stop_n, push, push_n;
    logic [DATA_BITS+1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_pop, do_push, full;

    // two-flop synchroniser for the asynchronous serial input, idles high
    always_ff @(posedge pclk) begin
        if (prst) {rx_s, rx_m} <= 2'b11;
        else {rx_s, rx_m} <= {rx_m, rx};
    end

    // free-running divider; the new baud_div is latched only on reload
    always_ff @(posedge pclk) begin
        if (prst) begin
            div_cnt   <= '0;
            div_lim   <= '0;
            baud_tick <= 1'b0;
        end else if (div_cnt == div_lim) begin
            div_cnt   <= '0;
            div_lim   <= baud_div;
            baud_tick <= 1'b1;
        end else begin
            div_cnt   <= div_cnt + 1'b1;
            baud_tick <= 1'b0;
        end
    end

    // receiver state register; reset abandons any frame in flight
    always_ff @(posedge pclk) begin
        if (prst) begin
            state    <= IDLE;
            s_cnt    <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            stop_idx <= 1'b0;
            push     <= 1'b0;
        end else begin
            state    <= state_n;
            s_cnt    <= s_n;
            bit_cnt  <= bit_n;
            shreg    <= sh_n;
            perr     <= perr_n;
            ferr     <= ferr_n;
            stop_idx <= stop_n;
            push     <= push_n;
        end
    end

    // next-state: start qualified at half bit, later bits sampled mid-bit every OVERSAMPLE ticks
    always_comb begin
        state_n = state;
        s_n     = s_cnt;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        perr_n  = perr;
        ferr_n  = ferr;
        stop_n  = stop_idx;
        push_n  = 1'b0;
        if (baud_tick) begin
            s_n = s_cnt + 1'b1;
            case (state)
                IDLE: begin
                    s_n = '0;
                    if (!rx_s) state_n = START;
                end
                START: if (s_cnt == SW'(OVERSAMPLE/2-1)) begin
                    s_n     = '0;
                    bit_n   = '0;
                    perr_n  = 1'b0;
                    ferr_n  = 1'b0;
                    state_n = rx_s ? IDLE : DATA;
                end
                DATA: if (s_cnt == SW'(OVERSAMPLE-1)) begin
                    s_n    = '0;
                    sh_n   = {rx_s, shreg[DATA_BITS-1:1]};
                    bit_n  = bit_cnt + 1'b1;
                    stop_n = 1'b0;
`ifdef UART_RX_PARITY_EN
                    if (bit_cnt == BW'(DATA_BITS-1)) state_n = parity_en ? PARITY : STOP;
`else
                    if (bit_cnt == BW'(DATA_BITS-1)) state_n = STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (s_cnt == SW'(OVERSAMPLE-1)) begin
                    s_n     = '0;
                    perr_n  = (^shreg ^ rx_s) != parity_odd;
                    state_n = STOP;
                end
`endif
                STOP: if (s_cnt == SW'(OVERSAMPLE-1)) begin
                    s_n    = '0;
                    ferr_n = ferr | ~rx_s;
                    stop_n = 1'b1;
                    if (stop_idx == stop2) begin
                        push_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign full     = fifo_count == CW'(FIFO_DEPTH);
    assign do_pop   = rd_en && rd_valid;
    assign do_push  = push && (!full || do_pop);
    assign rd_valid = fifo_count != '0;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
    assign uart_irq = (fifo_count >= irq_level && irq_level != '0) || overrun;

    // FIFO storage needs no reset; unread entries are masked by rd_valid
    always_ff @(posedge pclk) begin
        if (do_push) mem[wr_ptr] <= {perr, ferr, shreg};
    end

    // FIFO pointers, occupancy and sticky overrun (set wins over clear)
    always_ff @(posedge pclk) begin
        if (prst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
        end else begin
            wr_ptr     <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr     <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            fifo_count <= fifo_count + CW'(do_push) - CW'(do_pop);
            overrun    <= (push && !do_push) ? 1'b1 : clr_ovr ? 1'b0 : overrun;
        end
    end
endmodule
